// File: rtl/decompressor_if.sv
// decompressor_if: compressed-word input and expanded-beat output handshakes
interface decompressor_if;
    logic [63:0]      comp_data;
    logic             comp_valid;
    logic             comp_ready;
    logic [15:0][7:0] out_data;
    logic [4:0]       out_num;
    logic             out_last;
    logic             out_valid;
    logic             out_ready;
    logic             fmt_err;
    modport master (
        output comp_data, comp_valid, out_ready,
        input  comp_ready, out_data, out_num, out_last, out_valid, fmt_err
    );
    modport slave (
        input  comp_data, comp_valid, out_ready,
        output comp_ready, out_data, out_num, out_last, out_valid, fmt_err
    );
endinterface

// File: rtl/decompressor.sv
// decompressor: expands 64-bit zero-run/value words into beats of up to 16 bytes
module decompressor (
    input logic           clk,
    input logic           rst,
    decompressor_if.slave bus
);
    localparam int LANES = 16;
    localparam int NUM_GRP = 5;
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXPAND = 1'b1;

    // group g (0-based) ends with its value byte
    function automatic logic emit_v(input logic [63:0] d, input int g);
        return d[62:60] == 3'd7 || 3'(g + 1) < d[62:60] || (3'(g + 1) == d[62:60] && d[63]);
    endfunction

    // element count contributed by group g; LG=6 words contribute nothing
    function automatic logic [6:0] grp_len(input logic [63:0] d, input int g);
        return (d[62:60] == 3'd7 || (d[62:60] != 3'd6 && 3'(g + 1) <= d[62:60]))
            ? 7'(d[12*g +: 4]) + 7'(emit_v(d, g)) : 7'd0;
    endfunction

    logic [0:0]               state;
    logic [63:0]              w;
    logic [6:0]               pos;
    logic [NUM_GRP-1:0][6:0]  vidx;
    logic [NUM_GRP-1:0]       has_v;
    logic [6:0]               total, in_total, left;
    logic [4:0]               num;
    logic                     last, expanding, fmt_q;

    assign expanding = state == EXPAND;
    assign left = total - pos;
    assign num = left > 7'd16 ? 5'd16 : left[4:0];
    assign last = left <= 7'd16;
    assign bus.comp_ready = state == IDLE && !rst;
    assign bus.out_valid = expanding;
    assign bus.out_num = expanding ? num : 5'd0;
    assign bus.out_last = expanding && last;
    assign bus.fmt_err = fmt_q;

    // element positions of each group's value byte, and word lengths
    always_comb begin
        total = '0;
        in_total = '0;
        for (int g = 0; g < NUM_GRP; g++) begin
            vidx[g] = total + 7'(w[12*g +: 4]);
            has_v[g] = emit_v(w, g);
            total = total + grp_len(w, g);
            in_total = in_total + grp_len(bus.comp_data, g);
        end
    end

    // every element is zero except at a group's value position
    always_comb begin
        bus.out_data = '0;
        for (int i = 0; i < LANES; i++)
            for (int g = 0; g < NUM_GRP; g++)
                if (expanding && 5'(i) < num && has_v[g] && pos + 7'(i) == vidx[g])
                    bus.out_data[i] = w[12*g+4 +: 8];
    end

    // accept words in IDLE, advance the cursor by out_num on each accepted beat
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            w <= '0;
            pos <= '0;
            fmt_q <= 1'b0;
        end else begin
            fmt_q <= state == IDLE && bus.comp_valid && bus.comp_data[62:60] == 3'd6;
            if (state == IDLE && bus.comp_valid) begin
                w <= bus.comp_data;
                pos <= '0;
                state <= in_total != 7'd0 ? EXPAND : IDLE;
            end else if (expanding && bus.out_ready) begin
                pos <= pos + 7'(num);
                if (last)
                    state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_decompressor.sv
// tb_decompressor: randomized self-checking bench against a byte-queue reference model
module tb_decompressor;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    decompressor_if bus ();
    decompressor dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [63:0] W_SIMPLE = {1'b1, 3'd2, 36'd0, 8'h22, 4'd0, 8'h11, 4'd3};
    localparam logic [63:0] W_FULL = {1'b0, 3'd7, 8'hA5, 4'hF, 8'hA4, 4'hF, 8'hA3, 4'hF, 8'hA2, 4'hF, 8'hA1, 4'hF};
    localparam logic [63:0] W_TRAIL = {1'b0, 3'd2, 36'd0, 8'h99, 4'd4, 8'h07, 4'd2};

    // reference: walk groups in order, Z zeros then V unless the last group drops it
    function automatic bq_t model(input logic [63:0] w);
        bq_t q;
        int lg = int'(w[62:60]);
        int ng = lg == 7 ? 5 : lg;
        q = {};
        if (lg == 0 || lg == 6) return q;
        for (int g = 0; g < ng; g++) begin
            for (int z = 0; z < int'(w[12*g +: 4]); z++) q.push_back(8'h00);
            if (g < ng - 1 || lg == 7 || w[63]) q.push_back(w[12*g+4 +: 8]);
        end
        return q;
    endfunction

    task automatic send(input logic [63:0] w);
        int n = 0;
        while (bus.comp_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL send_ready got=%b exp=1", bus.comp_ready);
        end
        bus.comp_data = w;
        bus.comp_valid = 1'b1;
        @(negedge clk);
        bus.comp_valid = 1'b0;
    endtask

    task automatic run_word(input logic [63:0] w, input string name, input int stall_beat, input int stall_len, input bit rnd);
        bq_t q = model(w);
        logic [15:0][7:0] e;
        int n, stalls, beat = 0;
        send(w);
        if (q.size() == 0) begin
            checks += 4;
            if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s empty_valid got=%b exp=0", name, bus.out_valid); end
            if (bus.fmt_err !== (w[62:60] == 3'd6)) begin errors++; $display("FAIL %s fmt_err got=%b exp=%b", name, bus.fmt_err, w[62:60] == 3'd6); end
            if (bus.comp_ready !== 1'b1) begin errors++; $display("FAIL %s empty_ready got=%b exp=1", name, bus.comp_ready); end
            @(negedge clk);
            if (bus.fmt_err !== 1'b0) begin errors++; $display("FAIL %s fmt_err_pulse got=%b exp=0", name, bus.fmt_err); end
            return;
        end
        while (q.size() > 0) begin
            n = q.size() > 16 ? 16 : q.size();
            e = '0;
            for (int i = 0; i < n; i++) e[i] = q[i];
            stalls = beat == stall_beat ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
            for (int s = 0; s <= stalls; s++) begin
                bus.out_ready = s == stalls;
                checks += 5;
                if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s b%0d valid got=%b exp=1", name, beat, bus.out_valid); end
                if (bus.out_num !== 5'(n)) begin errors++; $display("FAIL %s b%0d num got=%0d exp=%0d", name, beat, bus.out_num, n); end
                if (bus.out_last !== (q.size() <= 16)) begin errors++; $display("FAIL %s b%0d last got=%b exp=%b", name, beat, bus.out_last, q.size() <= 16); end
                if (bus.out_data !== e) begin errors++; $display("FAIL %s b%0d data got=%h exp=%h", name, beat, bus.out_data, e); end
                if (bus.comp_ready !== 1'b0) begin errors++; $display("FAIL %s b%0d comp_ready got=%b exp=0", name, beat, bus.comp_ready); end
                @(negedge clk);
            end
            bus.out_ready = 1'b0;
            repeat (n) void'(q.pop_front());
            beat++;
        end
        checks += 2;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s end_valid got=%b exp=0", name, bus.out_valid); end
        if (bus.comp_ready !== 1'b1) begin errors++; $display("FAIL %s end_ready got=%b exp=1", name, bus.comp_ready); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks += 6;
        if (bus.comp_ready !== 1'b0) begin errors++; $display("FAIL reset comp_ready got=%b exp=0", bus.comp_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_num !== 5'd0) begin errors++; $display("FAIL reset out_num got=%0d exp=0", bus.out_num); end
        if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last got=%b exp=0", bus.out_last); end
        if (bus.out_data !== '0) begin errors++; $display("FAIL reset out_data got=%h exp=0", bus.out_data); end
        if (bus.fmt_err !== 1'b0) begin errors++; $display("FAIL reset fmt_err got=%b exp=0", bus.fmt_err); end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.comp_ready !== 1'b1) begin errors++; $display("FAIL reset_release comp_ready got=%b exp=1", bus.comp_ready); end
    endtask

    task automatic test_simple();
        run_word(W_SIMPLE, "simple", -1, 0, 1'b0);
    endtask

    task automatic test_full();
        run_word(W_FULL, "full", -1, 0, 1'b0);
    endtask

    task automatic test_trailing();
        run_word(W_TRAIL, "trailing", -1, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_word(W_FULL, "backpressure", 1, 3, 1'b0);
    endtask

    task automatic test_special();
        run_word({1'b1, 3'd0, 60'h0123456789ABCDE}, "lg0", -1, 0, 1'b0);
        run_word({1'b1, 3'd6, 60'h0123456789ABCDE}, "lg6", -1, 0, 1'b0);
        run_word({1'b0, 3'd1, 48'hFFFFFFFFFFFF, 8'hAB, 4'h0}, "zero_elems", -1, 0, 1'b0);
    endtask

    task automatic test_reset_mid();
        send(W_FULL);
        for (int b = 0; b < 2; b++) begin
            checks += 2;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid b%0d valid got=%b exp=1", b, bus.out_valid); end
            if (bus.out_num !== 5'd16) begin errors++; $display("FAIL rst_mid b%0d num got=%0d exp=16", b, bus.out_num); end
            bus.out_ready = 1'b1;
            @(negedge clk);
            bus.out_ready = 1'b0;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid b2 valid got=%b exp=1", bus.out_valid); end
        rst = 1'b1;
        #1;
        checks += 3;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid async_valid got=%b exp=0", bus.out_valid); end
        if (bus.out_num !== 5'd0) begin errors++; $display("FAIL rst_mid async_num got=%0d exp=0", bus.out_num); end
        if (bus.comp_ready !== 1'b0) begin errors++; $display("FAIL rst_mid async_ready got=%b exp=0", bus.comp_ready); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks += 2;
        if (bus.comp_ready !== 1'b1) begin errors++; $display("FAIL rst_mid release_ready got=%b exp=1", bus.comp_ready); end
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid release_valid got=%b exp=0", bus.out_valid); end
        run_word(W_SIMPLE, "after_rst", -1, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [63:0] w;
        for (int k = 0; k < 40; k++) begin
            w = {$urandom, $urandom};
            run_word(w, $sformatf("rand%0d", k), -1, 0, 1'b1);
        end
    endtask

    initial begin
        bus.comp_data = '0;
        bus.comp_valid = 1'b0;
        bus.out_ready = 1'b0;
        test_reset();
        test_simple();
        test_full();
        test_trailing();
        test_backpressure();
        test_special();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
